io_read_ctrl: RTL

Memory-stage read-return controller for the pipelined processor's memory-mapped I/O. It consumes the region enables and button select produced by the address decoder, then aligns them with the one-cycle latency of the synchronous data, original-image and processed-image RAMs. It returns a single registered read word to the writeback path. It also owns the four board push-buttons: it synchronizes and debounces them and holds each press in a sticky flag that is cleared when software reads it.

---
 rtl/io_read_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/io_read_ctrl.sv
// io_read_ctrl -- memory-stage read-return controller for memory-mapped I/O.
// Aligns decoder enables with the one-cycle latency of the synchronous RAMs,
// returns one read word per request and owns the four board push-buttons
// (2-flop synchronizer, debouncer, sticky press flags cleared on read).
// Build option: define IO_BTN_DEBOUNCE_EN to enable the debounce counters;
// when undefined the stable level is the synchronizer output directly.

module io_read_ctrl #(
   parameter int WIDTH           = 32,
   parameter int PIX_W           = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             read_en,
   input  logic             mem_enb,
   input  logic             show_enb,
   input  logic             show_original_enb,
   input  logic             original_enb,
   input  logic             process_enb,
   input  logic             btn_enb,
   input  logic [1:0]       btn_selecc,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic [PIX_W-1:0] original_rdata,
   input  logic [PIX_W-1:0] process_rdata,
   input  logic [3:0]       buttons_raw,
   output logic [WIDTH-1:0] rdata,
   output logic             rdata_valid,
   output logic [3:0]       btn_pressed
);

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_MEM,
      SRC_ORIG,
      SRC_PROC,
      SRC_BTN
   } srcSel_t;

   // The debounce counter must be able to reach DEBOUNCE_CYCLES-1.
   if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : gCntTooNarrow
      $error("io_read_ctrl: CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   srcSel_t          w_srcNext;
   srcSel_t          r_srcSel;
   logic             r_valid;
   logic [1:0]       r_btnIdx;
   logic [WIDTH-1:0] w_rdataMux;
   logic [WIDTH-1:0] r_rdataHold;
   logic             w_writeOnlySel;

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       w_stable;
   logic [3:0]       r_stablePrev;
   logic [3:0]       w_btnRise;
   logic [3:0]       w_btnClear;
   logic [3:0]       r_btnPressed;

   // Write-only registers are recognised so that a read of them resolves to no source.
   assign w_writeOnlySel = show_enb | show_original_enb;

   // Resolve the request source with fixed priority mem > original > process > button.
   always_comb begin
      w_srcNext = SRC_NONE;
      if (mem_enb) begin
         w_srcNext = SRC_MEM;
      end else if (original_enb) begin
         w_srcNext = SRC_ORIG;
      end else if (process_enb) begin
         w_srcNext = SRC_PROC;
      end else if (btn_enb) begin
         w_srcNext = SRC_BTN;
      end else if (w_writeOnlySel) begin
         w_srcNext = SRC_NONE;
      end
   end

   // Capture the request so the return lines up with the RAMs' one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_srcSel <= SRC_NONE;
         r_btnIdx <= 2'd0;
      end else begin
         r_valid  <= read_en;
         r_srcSel <= read_en ? w_srcNext : SRC_NONE;
         if (read_en) begin
            r_btnIdx <= btn_selecc;
         end
      end
   end

   // Select the return word from the RAM data now valid, or the current button flag.
   always_comb begin
      w_rdataMux = '0;
      case (r_srcSel)
         SRC_MEM:  w_rdataMux = mem_rdata;
         SRC_ORIG: w_rdataMux[PIX_W-1:0] = original_rdata;
         SRC_PROC: w_rdataMux[PIX_W-1:0] = process_rdata;
         SRC_BTN:  w_rdataMux[0] = r_btnPressed[r_btnIdx];
         default:  w_rdataMux = '0;
      endcase
   end

   // Keep the last returned word so rdata holds steady between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdataHold <= '0;
      end else if (r_valid) begin
         r_rdataHold <= w_rdataMux;
      end
   end

   assign rdata       = r_valid ? w_rdataMux : r_rdataHold;
   assign rdata_valid = r_valid;

   // Two-flop synchronizer for the asynchronous board buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 4'b0;
         r_sync2 <= 4'b0;
      end else begin
         r_sync1 <= buttons_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef IO_BTN_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       r_stable;
   logic [CNT_W-1:0] r_debCnt [4];

   // Accept a new level only after it has disagreed with the stable level long enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stable <= 4'b0;
         for (int i = 0; i < 4; i++) begin
            r_debCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
               if (r_debCnt[i] == CntLast) begin
                  r_stable[i] <= r_sync2[i];
                  r_debCnt[i] <= '0;
               end else begin
                  r_debCnt[i] <= r_debCnt[i] + 1'b1;
               end
            end else begin
               r_debCnt[i] <= '0;
            end
         end
      end
   end

   assign w_stable = r_stable;
`else
   assign w_stable = r_sync2;
`endif

   // A rising stable level sets the flag; a returned button read clears its bit, set wins.
   always_comb begin
      w_btnRise  = w_stable & ~r_stablePrev;
      w_btnClear = 4'b0;
      if (r_valid && (r_srcSel == SRC_BTN)) begin
         w_btnClear[r_btnIdx] = 1'b1;
      end
   end

   // Track the previous stable level and update the sticky press flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stablePrev <= 4'b0;
         r_btnPressed <= 4'b0;
      end else begin
         r_stablePrev <= w_stable;
         r_btnPressed <= (r_btnPressed & ~w_btnClear) | w_btnRise;
      end
   end

   assign btn_pressed = r_btnPressed;

endmodule
